// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for a 5-stage pipeline.
// Tracks EX/MEM/WB destination records and registers the EX operand-mux selects.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              ex_valid_o,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EXM = 2'd1;
    localparam logic [1:0] SEL_MWB = 2'd2;

    logic              ex_valid_q, ex_rw_q, ex_mr_q;
    logic [REG_AW-1:0] ex_dst_q;
    logic              mem_valid_q, mem_rw_q, mem_mr_q;
    logic [REG_AW-1:0] mem_dst_q;
    logic              wb_valid_q, wb_rw_q, wb_mr_q;
    logic [REG_AW-1:0] wb_dst_q;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              ex_valid_d, ex_rw_d, ex_mr_d;
    logic [REG_AW-1:0] ex_dst_d;
    logic [1:0]        fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0]  cnt_d;

    // A producer matches only if it is live, writes, targets src and src is not $0.
    function automatic logic hit(input logic v, input logic rw,
                                 input logic [REG_AW-1:0] dst,
                                 input logic [REG_AW-1:0] src);
        return v && rw && (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] pick_sel(input logic [REG_AW-1:0] src,
                                            input logic exv, input logic exrw,
                                            input logic [REG_AW-1:0] exdst,
                                            input logic mv, input logic mrw,
                                            input logic [REG_AW-1:0] mdst);
        if (hit(exv, exrw, exdst, src))
            return SEL_EXM;
        else if (hit(mv, mrw, mdst, src))
            return SEL_MWB;
        else
            return SEL_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_comb begin
        stall = id_valid && ex_valid_q && ex_mr_q &&
                (hit(ex_valid_q, ex_rw_q, ex_dst_q, id_rs) ||
                 (id_uses_rt && hit(ex_valid_q, ex_rw_q, ex_dst_q, id_rt)));
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_dst_d   = '0;
        fwd_a_d    = SEL_RF;
        fwd_b_d    = SEL_RF;
        cnt_d      = stall ? sat_inc(cnt_q) : cnt_q;
        if (!flush && !stall && id_valid) begin
            ex_valid_d = 1'b1;
            ex_rw_d    = id_reg_write;
            ex_mr_d    = id_mem_read;
            ex_dst_d   = id_dst;
            fwd_a_d    = pick_sel(id_rs, ex_valid_q, ex_rw_q, ex_dst_q,
                                  mem_valid_q, mem_rw_q, mem_dst_q);
            if (id_uses_rt)
                fwd_b_d = pick_sel(id_rt, ex_valid_q, ex_rw_q, ex_dst_q,
                                   mem_valid_q, mem_rw_q, mem_dst_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_dst_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            mem_dst_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_mr_q     <= 1'b0;
            wb_dst_q    <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            cnt_q       <= '0;
        end else begin
            wb_valid_q  <= mem_valid_q;
            wb_rw_q     <= mem_rw_q;
            wb_mr_q     <= mem_mr_q;
            wb_dst_q    <= mem_dst_q;
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_mr_q    <= ex_mr_q;
            mem_dst_q   <= ex_dst_q;
            ex_valid_q  <= ex_valid_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            ex_dst_q    <= ex_dst_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            cnt_q       <= cnt_d;
        end
    end

    // The WB record is kept for visibility/extension; nothing downstream consumes it here.
    logic wb_unused;
    assign wb_unused = wb_valid_q ^ wb_rw_q ^ wb_mr_q ^ (^wb_dst_q) ^ mem_mr_q;

    assign fwd_a_sel    = fwd_a_q;
    assign fwd_b_sel    = fwd_b_q;
    assign ex_valid_o   = ex_valid_q;
    assign stall_cycles = cnt_q;

endmodule
